// File: rtl/adder_pair_4b.sv
// Registered 4-bit adder computing a+b+cin with independent ripple-carry and CLA structures.
// Latency 2 edges, one operation per cycle, no backpressure; mismatch flags disagreement.
module adder_pair_4b #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH:0]   sum_ripple,
   output logic [WIDTH:0]   sum_cla,
   output logic             grp_g,
   output logic             grp_p,
   output logic             mismatch
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             cin_q;
   logic             v1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         cin_q <= 1'b0;
         v1    <= 1'b0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            cin_q <= cin;
         end
      end
   end

   // Ripple-carry chain: each carry feeds the next full adder.
   logic [WIDTH:0]   rc;
   logic [WIDTH-1:0] rs;

   always_comb begin
      rc    = '0;
      rs    = '0;
      rc[0] = cin_q;
      for (int i = 0; i < WIDTH; i++) begin
         rs[i]   = a_q[i] ^ b_q[i] ^ rc[i];
         rc[i+1] = (a_q[i] & b_q[i]) | (rc[i] & (a_q[i] ^ b_q[i]));
      end
   end

   // Single lookahead group; carries are flat sum-of-products, never chained.
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [WIDTH:0]   lc;
   logic [WIDTH-1:0] ls;
   logic             gg;
   logic             gp;

   assign g = a_q & b_q;
   assign p = a_q ^ b_q;

   assign lc[0] = cin_q;
   assign lc[1] = g[0] | (p[0] & cin_q);
   assign lc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_q);
   assign lc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_q);
   assign lc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin_q);

   assign ls = p ^ lc[WIDTH-1:0];
   assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign gp = &p;

   logic [WIDTH:0] r_sum;
   logic [WIDTH:0] l_sum;

   assign r_sum = {rc[WIDTH], rs};
   assign l_sum = {lc[WIDTH], ls};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         sum_ripple <= '0;
         sum_cla    <= '0;
         grp_g      <= 1'b0;
         grp_p      <= 1'b0;
         mismatch   <= 1'b0;
      end else begin
         out_valid <= v1;
         if (v1) begin
            sum_ripple <= r_sum;
            sum_cla    <= l_sum;
            grp_g      <= gg;
            grp_p      <= gp;
            mismatch   <= (r_sum != l_sum);
         end
      end
   end

endmodule

// File: tb/tb_adder_pair_4b.sv
// Directed and exhaustive checks of adder_pair_4b against hand-computed sums.
module tb_adder_pair_4b;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       out_valid;
   logic [4:0] sum_ripple;
   logic [4:0] sum_cla;
   logic       grp_g;
   logic       grp_p;
   logic       mismatch;

   int tests;
   int fails;

   adder_pair_4b #(.WIDTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .a          (a),
      .b          (b),
      .cin        (cin),
      .out_valid  (out_valid),
      .sum_ripple (sum_ripple),
      .sum_cla    (sum_cla),
      .grp_g      (grp_g),
      .grp_p      (grp_p),
      .mismatch   (mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "timeout");
   end

   task automatic step(input logic v, input logic [3:0] va, input logic [3:0] vb, input logic vc);
      in_valid = v;
      a        = va;
      b        = vb;
      cin      = vc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      step(1'b0, 4'd0, 4'd0, 1'b0);
      tests++;
      if ({out_valid, sum_ripple, sum_cla, grp_g, grp_p, mismatch} !== 14'd0) begin
         fails++;
         $display("FAIL reset_initial: got ov=%b sr=%0d sc=%0d g=%b p=%b mm=%b, want all 0",
                  out_valid, sum_ripple, sum_cla, grp_g, grp_p, mismatch);
      end
      rst_n = 1'b1;
      step(1'b1, 4'd15, 4'd15, 1'b1);
      step(1'b1, 4'd9, 4'd9, 1'b0);
      tests++;
      if (out_valid !== 1'b1 || sum_ripple !== 5'd31) begin
         fails++;
         $display("FAIL reset_prefill: got ov=%b sr=%0d, want ov=1 sr=31", out_valid, sum_ripple);
      end
      // operand 9+9 is now in flight; assert reset mid-cycle
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({out_valid, sum_ripple, sum_cla, grp_g, grp_p, mismatch} !== 14'd0) begin
         fails++;
         $display("FAIL reset_async: got ov=%b sr=%0d sc=%0d g=%b p=%b mm=%b, want all 0",
                  out_valid, sum_ripple, sum_cla, grp_g, grp_p, mismatch);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 4'd5, 4'd5, 1'b1);
         tests++;
         if (out_valid !== 1'b0 || sum_ripple !== 5'd0 || sum_cla !== 5'd0) begin
            fails++;
            $display("FAIL reset_no_stale[%0d]: got ov=%b sr=%0d sc=%0d, want 0 0 0",
                     i, out_valid, sum_ripple, sum_cla);
         end
      end
   endtask

   task automatic test_directed;
      logic [3:0] va  [5] = '{4'd7, 4'd15, 4'd15, 4'd7, 4'd15};
      logic [3:0] vb  [5] = '{4'd15, 4'd0, 4'd0, 4'd15, 4'd0};
      logic       vc  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [4:0] exs [5] = '{5'd22, 5'd15, 5'd16, 5'd22, 5'd15};
      logic       exg [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic       exp [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i <= 5; i++) begin
         if (i < 5) step(1'b1, va[i], vb[i], vc[i]);
         else       step(1'b0, 4'd3, 4'd3, 1'b1);
         if (i > 0) begin
            tests++;
            if (out_valid !== 1'b1 || sum_ripple !== exs[i-1] || sum_cla !== exs[i-1] ||
                mismatch !== 1'b0 || grp_g !== exg[i-1] || grp_p !== exp[i-1]) begin
               fails++;
               $display("FAIL directed[%0d]: got ov=%b sr=%0d sc=%0d g=%b p=%b mm=%b, want ov=1 sum=%0d g=%b p=%b mm=0",
                        i-1, out_valid, sum_ripple, sum_cla, grp_g, grp_p, mismatch,
                        exs[i-1], exg[i-1], exp[i-1]);
            end
         end
      end
      step(1'b0, 4'd3, 4'd3, 1'b1);
      tests++;
      if (out_valid !== 1'b0 || sum_ripple !== 5'd15 || sum_cla !== 5'd15) begin
         fails++;
         $display("FAIL directed_tail: got ov=%b sr=%0d sc=%0d, want ov=0 sums held at 15",
                  out_valid, sum_ripple, sum_cla);
      end
   endtask

   task automatic test_corners;
      logic [3:0] va  [3] = '{4'd0, 4'd15, 4'd8};
      logic [3:0] vb  [3] = '{4'd0, 4'd15, 4'd8};
      logic       vc  [3] = '{1'b0, 1'b1, 1'b0};
      logic [4:0] exs [3] = '{5'd0, 5'd31, 5'd16};
      logic       exg [3] = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i <= 3; i++) begin
         if (i < 3) step(1'b1, va[i], vb[i], vc[i]);
         else       step(1'b0, 4'd0, 4'd0, 1'b0);
         if (i > 0) begin
            tests++;
            if (out_valid !== 1'b1 || sum_ripple !== exs[i-1] || sum_cla !== exs[i-1] ||
                mismatch !== 1'b0 || grp_g !== exg[i-1] || grp_p !== 1'b0) begin
               fails++;
               $display("FAIL corner[%0d]: got ov=%b sr=%0d sc=%0d g=%b p=%b mm=%b, want ov=1 sum=%0d g=%b p=0 mm=0",
                        i-1, out_valid, sum_ripple, sum_cla, grp_g, grp_p, mismatch,
                        exs[i-1], exg[i-1]);
            end
         end
      end
   endtask

   task automatic test_exhaustive;
      logic [4:0] prev;
      prev = 5'd0;
      for (int n = 0; n <= 512; n++) begin
         logic [3:0] ta;
         logic [3:0] tb;
         logic       tc;
         ta = n[3:0];
         tb = n[7:4];
         tc = n[8];
         if (n < 512) step(1'b1, ta, tb, tc);
         else         step(1'b0, 4'd0, 4'd0, 1'b0);
         if (n > 0) begin
            tests++;
            if (out_valid !== 1'b1 || sum_ripple !== prev || sum_cla !== prev || mismatch !== 1'b0) begin
               fails++;
               $display("FAIL exhaustive[%0d]: got ov=%b sr=%0d sc=%0d mm=%b, want ov=1 sum=%0d mm=0",
                        n-1, out_valid, sum_ripple, sum_cla, mismatch, prev);
            end
         end
         prev = {1'b0, ta} + {1'b0, tb} + {4'd0, tc};
      end
   endtask

   task automatic test_valid_gating;
      logic       vv  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [3:0] va  [5] = '{4'd3, 4'd9, 4'd1, 4'd14, 4'd14};
      logic [3:0] vb  [5] = '{4'd4, 4'd9, 4'd2, 4'd13, 4'd13};
      logic       vc  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic       eov [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [4:0] exs [5] = '{5'd0, 5'd7, 5'd7, 5'd4, 5'd4};
      step(1'b0, 4'd0, 4'd0, 1'b0);
      step(1'b0, 4'd0, 4'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(vv[i], va[i], vb[i], vc[i]);
         if (i > 0) begin
            tests++;
            if (out_valid !== eov[i] || sum_ripple !== exs[i] || sum_cla !== exs[i]) begin
               fails++;
               $display("FAIL valid_gating[%0d]: got ov=%b sr=%0d sc=%0d, want ov=%b sum=%0d",
                        i, out_valid, sum_ripple, sum_cla, eov[i], exs[i]);
            end
         end
      end
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = 4'd0;
      b        = 4'd0;
      cin      = 1'b0;
      test_reset();
      test_directed();
      test_corners();
      test_exhaustive();
      test_valid_gating();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
